alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute/writeback stage sitting directly downstream of the 4x32 register file.
//  - Consumes the A/B read data and the destination select.
//  - Computes an ALU or sequential-multiply result.
//  - Drives the register file write port (enable/Dsel/Ddata).
//  - Single-cycle ops issue back-to-back; MUL stalls issue through a ready/valid handshake.
// PARAMETERS
//  DATA_W  32  operand/result width
//  SEL_W   2   register select width (4 registers)
//  OP_W    4   opcode width
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous, active-high reset
//  in_valid    in   1       issue request
//  in_ready    out  1       stage can accept (state==IDLE)
//  in_op       in   OP_W    opcode
//  in_dsel     in   SEL_W   destination register
//  in_a        in   DATA_W  operand A (regfile Adata)
//  in_b        in   DATA_W  operand B (regfile Bdata)
//  wb_enable   out  1       regfile write strobe, 1-cycle pulse
//  wb_dsel     out  SEL_W   regfile Dsel
//  wb_data     out  DATA_W  regfile Ddata
//  flag_z/n/c/v out 1 each  zero/negative/carry/overflow of last written result
//  illegal_op  out  1       1-cycle pulse on undefined opcode
// BEHAVIOUR
//  - One clock (clk). Synchronous active-high rst: every output reg and the FSM go to 0/IDLE.
//    After reset, in_ready=1.
//  - Accept = in_valid & in_ready. in_op/in_dsel/in_a/in_b are latched on accept; later
//    input changes have no effect on that op.
//  - Opcodes:
//    0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR,
//    5 SLL, 6 SRL, 7 SRA (shift amount in_b[4:0]),
//    8 SLT (signed, result 0/1), 9 PASSA, 10 MUL (low DATA_W bits).
//    11..15 illegal.
//  - Single-cycle op accepted in cycle T: wb_enable=1, wb_dsel and wb_data valid in T+1.
//    FSM stays IDLE, so a new op may be accepted every cycle.
//  - FSM states:
//    IDLE: accept MUL -> MUL.
//    MUL: shift-add, one bit per cycle, 5-bit counter 0..31; in_ready=0.
//    At count==31 -> IDLE.
//  - MUL accepted in T: iterations in T+1..T+32; wb_enable pulses in T+33. in_ready returns
//    to 1 in T+33, so a new op may be accepted in the same cycle as the MUL writeback.
//  - wb_enable is 0 whenever no result is written. wb_dsel/wb_data hold their last value.
//  - Flags update only on cycles where wb_enable=1:
//    Z = (wb_data==0); N = wb_data[DATA_W-1].
//    C/V: ADD = carry-out / signed overflow. SUB is computed as a+~b+1; C=1 means no borrow.
//    All other ops: C and V are cleared.
//  - Illegal op: accepted normally. In T+1: illegal_op=1, wb_enable=0, flags unchanged.
//  - rst during MUL abandons the op: no writeback, in_ready=1 in the cycle after reset.
//  - in_valid while in_ready=0 is ignored; the upstream holds the request.
//  - Arithmetic wraps modulo 2^DATA_W. Shift amounts >= DATA_W cannot occur (5-bit field).
// CONFIGURATION
//  - ALU_MUL_EN defined: opcode 10 is MUL as above.
//  - ALU_MUL_EN undefined: multiplier and MUL state are compiled out. Opcode 10 is illegal
//    (illegal_op pulse, no writeback). in_ready is then constantly 1 outside reset.
// STRUCTURE
//  - Shared package alu_pkg: opcode localparams (OP_ADD..OP_MUL), state encoding
//    (ST_IDLE, ST_MUL), DATA_W/SEL_W defaults.
//  - Sub-module alu_seq_mul: start/done shift-add multiplier with its own counter.
//    Instantiated only under ALU_MUL_EN.
//  - Top level contains the combinational ALU, the FSM and the writeback/flag registers.
// TESTING
//  1. After rst: wb_enable=0, flags=0, in_ready=1.
//     ADD a=5 b=7 dsel=2 -> next cycle wb_enable=1, wb_dsel=2, wb_data=12, Z=0.
//  2. SUB a=0 b=1 -> wb_data=0xFFFFFFFF, N=1, C=0, V=0.
//     ADD 0x7FFFFFFF+1 -> 0x80000000, V=1, N=1.
//  3. Back-to-back AND/OR/XOR/SRA on 3 consecutive cycles -> 3 consecutive wb pulses.
//     Check SRA 0x80000000 by 4 -> 0xF8000000.
//  4. MUL 7*6 dsel=1 accepted at T -> in_ready=0 T+1..T+32; wb_data=42 at T+33.
//     in_valid held during the MUL is not accepted early.
//  5. MUL started, rst asserted at T+10 -> no wb_enable ever; in_ready=1 next cycle.
//     A following ADD works normally.
//  6. op=15 -> illegal_op pulse, wb_enable=0, flags unchanged.
//     Repeat op=10 with ALU_MUL_EN undefined -> same response.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and widths for the ALU execute stage (ALU_MUL_EN)
package alu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEL_W  = 2;
  localparam int DEF_OP_W   = 4;
  localparam int SHAMT_W    = 5;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_PASSA = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Opcode 10 is only a real instruction when the multiplier is built in.
  function automatic logic op_is_legal(input logic [3:0] op);
`ifdef ALU_MUL_EN
    return (op <= OP_MUL);
`else
    return (op <= OP_PASSA);
`endif
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - issue and register-file writeback bundle of the ALU execute stage
interface alu_exec_if #(
  parameter int DATA_W = alu_pkg::DEF_DATA_W,
  parameter int SEL_W  = alu_pkg::DEF_SEL_W,
  parameter int OP_W   = alu_pkg::DEF_OP_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [SEL_W-1:0]  in_dsel;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  logic              wb_enable;
  logic [SEL_W-1:0]  wb_dsel;
  logic [DATA_W-1:0] wb_data;
  logic              flag_z;
  logic              flag_n;
  logic              flag_c;
  logic              flag_v;
  logic              illegal_op;

  // Upstream issuer / register-file side.
  modport master (
    output in_valid, in_op, in_dsel, in_a, in_b,
    input  in_ready, wb_enable, wb_dsel, wb_data,
    input  flag_z, flag_n, flag_c, flag_v, illegal_op
  );

  // The execute stage itself.
  modport slave (
    input  in_valid, in_op, in_dsel, in_a, in_b,
    output in_ready, wb_enable, wb_dsel, wb_data,
    output flag_z, flag_n, flag_c, flag_v, illegal_op
  );

endinterface

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - shift-add multiplier, one multiplier bit per cycle, low-half product
module alu_seq_mul #(
  parameter int DATA_W = alu_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int CNT_W = $clog2(DATA_W);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  // Partial-product accumulate for the current multiplier bit.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // The last iteration's sum is the product, so it is presented in the done cycle.
  assign done_o   = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
  assign result_o = acc_d;

  // Load operands on start, then shift one bit per cycle until the counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute/writeback stage for the 4x32 register file (ALU_MUL_EN adds MUL)
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  exec_if
);

  logic              accept;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W:0]   sum_add;
  logic [DATA_W:0]   sum_sub;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic              op_legal;
  logic              op_is_mul;

  logic              wb_enable_q, wb_enable_d;
  logic [SEL_W-1:0]  wb_dsel_q,   wb_dsel_d;
  logic [DATA_W-1:0] wb_data_q,   wb_data_d;
  logic              flag_z_q,    flag_z_d;
  logic              flag_n_q,    flag_n_d;
  logic              flag_c_q,    flag_c_d;
  logic              flag_v_q,    flag_v_d;
  logic              illegal_q,   illegal_d;

  logic              mul_done;
  logic [DATA_W-1:0] mul_result;
  logic [SEL_W-1:0]  mul_dsel_q;

  assign accept = exec_if.in_valid & exec_if.in_ready;
  assign op_a   = exec_if.in_a;
  assign op_b   = exec_if.in_b;
  assign shamt  = op_b[SHAMT_W-1:0];

  // SUB is a + ~b + 1 so the carry-out reads as "no borrow".
  assign sum_add = {1'b0, op_a} + {1'b0, op_b};
  assign sum_sub = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};

  // Combinational ALU on the live inputs; results are captured only on accept.
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    op_is_mul = 1'b0;
    op_legal  = op_is_legal(exec_if.in_op);
    case (exec_if.in_op)
      OP_ADD: begin
        alu_res = sum_add[DATA_W-1:0];
        alu_c   = sum_add[DATA_W];
        alu_v   = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = sum_sub[DATA_W-1:0];
        alu_c   = sum_sub[DATA_W];
        alu_v   = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_SLL:   alu_res = op_a << shamt;
      OP_SRL:   alu_res = op_a >> shamt;
      OP_SRA:   alu_res = $signed(op_a) >>> shamt;
      OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_PASSA: alu_res = op_a;
      OP_MUL:   op_is_mul = op_legal;
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  state_t state_q, state_d;
  logic   mul_start;

  // FSM next state: leave IDLE on an accepted MUL, return when the multiplier finishes.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && op_is_mul) begin
          state_d   = ST_MUL;
          mul_start = 1'b1;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and the destination held for the in-flight multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mul_dsel_q <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) begin
        mul_dsel_q <= exec_if.in_dsel;
      end
    end
  end

  assign exec_if.in_ready = (state_q == ST_IDLE);

  alu_seq_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (op_a),
    .b_i      (op_b),
    .done_o   (mul_done),
    .result_o (mul_result)
  );
`else
  assign exec_if.in_ready = 1'b1;
  assign mul_done         = 1'b0;
  assign mul_result       = '0;
  assign mul_dsel_q       = '0;
`endif

  // Writeback/flag next state: one pulse per written result, everything else holds.
  always_comb begin
    wb_enable_d = 1'b0;
    wb_dsel_d   = wb_dsel_q;
    wb_data_d   = wb_data_q;
    flag_z_d    = flag_z_q;
    flag_n_d    = flag_n_q;
    flag_c_d    = flag_c_q;
    flag_v_d    = flag_v_q;
    illegal_d   = 1'b0;
    if (accept && !op_is_mul) begin
      if (op_legal) begin
        wb_enable_d = 1'b1;
        wb_dsel_d   = exec_if.in_dsel;
        wb_data_d   = alu_res;
        flag_z_d    = (alu_res == '0);
        flag_n_d    = alu_res[DATA_W-1];
        flag_c_d    = alu_c;
        flag_v_d    = alu_v;
      end else begin
        illegal_d   = 1'b1;
      end
    end
    if (mul_done) begin
      wb_enable_d = 1'b1;
      wb_dsel_d   = mul_dsel_q;
      wb_data_d   = mul_result;
      flag_z_d    = (mul_result == '0);
      flag_n_d    = mul_result[DATA_W-1];
      flag_c_d    = 1'b0;
      flag_v_d    = 1'b0;
    end
  end

  // Writeback port and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_enable_q <= 1'b0;
      wb_dsel_q   <= '0;
      wb_data_q   <= '0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      wb_enable_q <= wb_enable_d;
      wb_dsel_q   <= wb_dsel_d;
      wb_data_q   <= wb_data_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
      illegal_q   <= illegal_d;
    end
  end

  assign exec_if.wb_enable  = wb_enable_q;
  assign exec_if.wb_dsel    = wb_dsel_q;
  assign exec_if.wb_data    = wb_data_q;
  assign exec_if.flag_z     = flag_z_q;
  assign exec_if.flag_n     = flag_n_q;
  assign exec_if.flag_c     = flag_c_q;
  assign exec_if.flag_v     = flag_v_q;
  assign exec_if.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage (ALU_MUL_EN aware)
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_exec_if bus ();

  alu_exec_stage dut (
    .clk     (clk),
    .rst     (rst),
    .exec_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; returns at the sampling point of the next cycle.
  task automatic issue(input logic [3:0] op, input logic [1:0] dsel,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_dsel  = dsel;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_wb(input string tag, input logic [1:0] dsel, input logic [31:0] data,
                          input logic z, input logic n, input logic c, input logic v);
    check({tag, ".en"},   32'(bus.wb_enable), 32'd1);
    check({tag, ".dsel"}, 32'(bus.wb_dsel),   32'(dsel));
    check({tag, ".data"}, bus.wb_data,        data);
    check({tag, ".flags"}, 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}),
          32'({z, n, c, v}));
  endtask

`ifdef ALU_MUL_EN
  task automatic do_mul(input string tag, input logic [1:0] dsel,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod);
    int lat;
    issue(OP_MUL, dsel, a, b);
    lat = 1;
    while (!bus.wb_enable && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'd33);
    check_wb(tag, dsel, prod, (prod == 32'd0), prod[31], 1'b0, 1'b0);
  endtask
`endif

  initial begin
    int seen_wb;
    n_cmp = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_dsel  = '0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst.wb_enable", 32'(bus.wb_enable), 32'd0);
    check("rst.flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.illegal", 32'(bus.illegal_op), 32'd0);

    // Basic ADD and pulse width
    issue(OP_ADD, 2'd2, 32'd5, 32'd7);
    check_wb("add5_7", 2'd2, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("add.pulse_end", 32'(bus.wb_enable), 32'd0);
    check("add.data_hold", bus.wb_data, 32'd12);

    // SUB / ADD flag corners
    issue(OP_SUB, 2'd3, 32'd0, 32'd1);
    check_wb("sub0_1", 2'd3, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(OP_ADD, 2'd0, 32'h7FFF_FFFF, 32'd1);
    check_wb("add_ovf", 2'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(OP_SUB, 2'd1, 32'd5, 32'd5);
    check_wb("sub5_5", 2'd1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(OP_SUB, 2'd1, 32'h8000_0000, 32'd1);
    check_wb("sub_ovf", 2'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(OP_ADD, 2'd2, 32'hFFFF_FFFF, 32'd1);
    check_wb("add_carry", 2'd2, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-to-back logic/shift ops, one per cycle
    bus.in_valid = 1'b1;
    bus.in_op = OP_AND; bus.in_dsel = 2'd1; bus.in_a = 32'hF0F0_F0F0; bus.in_b = 32'hFF00_FF00;
    @(negedge clk);
    check_wb("and", 2'd1, 32'hF000_F000, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.in_op = OP_OR;  bus.in_dsel = 2'd2; bus.in_a = 32'h0F0F_0000; bus.in_b = 32'h0000_00F0;
    @(negedge clk);
    check_wb("or", 2'd2, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_op = OP_XOR; bus.in_dsel = 2'd3; bus.in_a = 32'hFFFF_0000; bus.in_b = 32'h0F0F_0F0F;
    @(negedge clk);
    check_wb("xor", 2'd3, 32'hF0F0_0F0F, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.in_op = OP_SRA; bus.in_dsel = 2'd0; bus.in_a = 32'h8000_0000; bus.in_b = 32'd4;
    @(negedge clk);
    check_wb("sra", 2'd0, 32'hF800_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.in_op = OP_SLL; bus.in_dsel = 2'd1; bus.in_a = 32'd1; bus.in_b = 32'hFFFF_FFFF;
    @(negedge clk);
    check_wb("sll31", 2'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.in_op = OP_SRL; bus.in_dsel = 2'd2; bus.in_a = 32'h8000_0000; bus.in_b = 32'd31;
    @(negedge clk);
    check_wb("srl31", 2'd2, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_op = OP_SLT; bus.in_dsel = 2'd3; bus.in_a = 32'hFFFF_FFFF; bus.in_b = 32'd1;
    @(negedge clk);
    check_wb("slt_neg", 2'd3, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_op = OP_SLT; bus.in_dsel = 2'd3; bus.in_a = 32'd1; bus.in_b = 32'hFFFF_FFFF;
    @(negedge clk);
    check_wb("slt_pos", 2'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.in_op = OP_PASSA; bus.in_dsel = 2'd0; bus.in_a = 32'hDEAD_BEEF; bus.in_b = 32'd0;
    @(negedge clk);
    check_wb("passa", 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b.pulse_end", 32'(bus.wb_enable), 32'd0);

`ifdef ALU_MUL_EN
    // MUL latency, stall and held request
    issue(OP_ADD, 2'd2, 32'hFFFF_FFFF, 32'd1);
    issue(OP_MUL, 2'd1, 32'd7, 32'd6);
    bus.in_valid = 1'b1;
    bus.in_op = OP_ADD; bus.in_dsel = 2'd3; bus.in_a = 32'd1; bus.in_b = 32'd1;
    check("mul.ready_t1", 32'(bus.in_ready), 32'd0);
    for (int k = 2; k <= 32; k++) begin
      @(negedge clk);
      check($sformatf("mul.stall_t%0d", k), 32'({bus.in_ready, bus.wb_enable}), 32'd0);
    end
    @(negedge clk);
    check("mul.ready_t33", 32'(bus.in_ready), 32'd1);
    check_wb("mul7_6", 2'd1, 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_wb("held_add", 2'd3, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    do_mul("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    do_mul("mul_wrap", 2'd2, 32'h0001_0000, 32'h0001_0000, 32'd0);
    do_mul("mul_neg", 2'd3, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);

    // Reset in the middle of a MUL abandons it
    issue(OP_MUL, 2'd2, 32'd3, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.ready", 32'(bus.in_ready), 32'd1);
    seen_wb = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.wb_enable) seen_wb++;
      @(negedge clk);
    end
    check("abort.no_wb", 32'(seen_wb), 32'd0);
    check("abort.data_rst", bus.wb_data, 32'd0);
    issue(OP_ADD, 2'd0, 32'd2, 32'd3);
    check_wb("after_abort", 2'd0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Illegal opcodes leave writeback state and flags untouched
    issue(OP_ADD, 2'd3, 32'h7FFF_FFFF, 32'd1);
    check_wb("pre_ill", 2'd3, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(4'd15, 2'd1, 32'd0, 32'd0);
    check("ill15.pulse", 32'(bus.illegal_op), 32'd1);
    check("ill15.no_wb", 32'(bus.wb_enable), 32'd0);
    check("ill15.hold", bus.wb_data, 32'h8000_0000);
    check("ill15.dsel", 32'(bus.wb_dsel), 32'd3);
    check("ill15.flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'b0101);
    @(negedge clk);
    check("ill15.pulse_end", 32'(bus.illegal_op), 32'd0);
    issue(4'd11, 2'd0, 32'd1, 32'd1);
    check("ill11.pulse", 32'(bus.illegal_op), 32'd1);
    check("ill11.no_wb", 32'(bus.wb_enable), 32'd0);
`ifndef ALU_MUL_EN
    issue(OP_MUL, 2'd2, 32'd7, 32'd6);
    check("ill10.pulse", 32'(bus.illegal_op), 32'd1);
    check("ill10.no_wb", 32'(bus.wb_enable), 32'd0);
    check("ill10.ready", 32'(bus.in_ready), 32'd1);
    check("ill10.flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'b0101);
    check("ill10.hold", bus.wb_data, 32'h8000_0000);
`endif
    @(negedge clk);
    check("ill.pulse_end", 32'(bus.illegal_op), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
